// File: rtl/la_cap_pkg.sv
// Shared types for the logic-analyser capture engine: FSM state encoding,
// trigger-mode codes and the trigger-hit rule.
package la_cap_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } cap_state_t;

   localparam logic [1:0] TM_LEVEL = 2'd0;
   localparam logic [1:0] TM_RISE  = 2'd1;
   localparam logic [1:0] TM_FALL  = 2'd2;
   localparam logic [1:0] TM_IMM   = 2'd3;

   // Trigger decision for one sample, given this sample's match and the previous one.
   function automatic logic trig_hit(input logic [1:0] mode, input logic match, input logic prev);
      case (mode)
         TM_LEVEL: trig_hit = match;
         TM_RISE:  trig_hit = match && !prev;
         TM_FALL:  trig_hit = !match && prev;
         default:  trig_hit = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/la_cap_if.sv
// Debug-side port bundle of the capture engine. The bridge (JTAG/UART) side
// uses the master modport; the capture core uses the slave modport.
interface la_cap_if #(
   parameter int DATA_W = 22,
   parameter int RD_W   = 22
);
   logic              I_sample_en;
   logic [DATA_W-1:0] I_data;
   logic              I_arm;
   logic              I_abort;
   logic [1:0]        I_trig_mode;
   logic [DATA_W-1:0] I_trig_mask;
   logic [DATA_W-1:0] I_trig_value;
   logic              I_rd_req;
   logic [RD_W-1:0]   O_rd_data;
   logic              O_rd_valid;
   logic              O_rd_last;
   logic [2:0]        O_state;
   logic              O_triggered;
   logic              O_done;

   modport master (
      output I_sample_en, I_data, I_arm, I_abort, I_trig_mode, I_trig_mask, I_trig_value, I_rd_req,
      input  O_rd_data, O_rd_valid, O_rd_last, O_state, O_triggered, O_done
   );

   modport slave (
      input  I_sample_en, I_data, I_arm, I_abort, I_trig_mode, I_trig_mask, I_trig_value, I_rd_req,
      output O_rd_data, O_rd_valid, O_rd_last, O_state, O_triggered, O_done
   );
endinterface

// File: rtl/la_cap_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read,
// no reset on the array so it maps onto block RAM.
module la_cap_ram #(
   parameter int WIDTH = 22,
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Write port and one-cycle registered read port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture core: circular sample buffer with masked-compare
// trigger, PRE_TRIG samples kept ahead of the trigger, oldest-first readout.
// Optional macro LA_CAP_TSTAMP_EN stores a TS_W sample timestamp with each word.
//
// state | meaning
// IDLE  | not capturing, buffer contents undefined
// PRE   | filling the PRE_TRIG pre-trigger samples, hits ignored
// ARMED | writing circularly, waiting for a trigger hit
// POST  | filling the samples after the trigger
// DONE  | window complete, readable via rd_req
module la_capture_core
   import la_cap_pkg::*;
#(
   parameter int DATA_W   = 22,
   parameter int DEPTH    = 256,
   parameter int PRE_TRIG = 64,
   parameter int TS_W     = 16
) (
   input logic     I_clk,
   input logic     I_rst,
   la_cap_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
`ifdef LA_CAP_TSTAMP_EN
   localparam int RD_W = DATA_W + TS_W;
`else
   localparam int RD_W = DATA_W + 0 * TS_W;
`endif
   localparam logic [CW-1:0] PRE_CNT   = CW'(PRE_TRIG);
   localparam logic [CW-1:0] POST_CNT  = CW'(DEPTH - PRE_TRIG);
   localparam cap_state_t    ARM_STATE = (PRE_TRIG == 0) ? ST_ARMED : ST_PRE;

   cap_state_t    state, state_nxt;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] pre_cnt, post_cnt;
   logic          prev_match, triggered, done, rd_valid, rd_last;
   logic          match, hit, arm_ok, wr_en, rd_en;
   logic [RD_W-1:0] wr_word, rd_word;

   assign match  = ((bus.I_data ^ bus.I_trig_value) & bus.I_trig_mask) == '0;
   assign hit    = trig_hit(bus.I_trig_mode, match, prev_match);
   assign arm_ok = bus.I_arm && !bus.I_abort && (state == ST_IDLE || state == ST_DONE);
   assign wr_en  = bus.I_sample_en && !bus.I_abort &&
                   (state == ST_PRE || state == ST_ARMED || state == ST_POST);
   assign rd_en  = bus.I_rd_req && !bus.I_abort && (state == ST_DONE);

`ifdef LA_CAP_TSTAMP_EN
   logic [TS_W-1:0] ts_cnt;

   // Sample timestamp: counts strobes, restarts at every accepted arm.
   always_ff @(posedge I_clk) begin
      if (I_rst)            ts_cnt <= '0;
      else if (arm_ok)      ts_cnt <= '0;
      else if (bus.I_sample_en) ts_cnt <= ts_cnt + TS_W'(1);
   end

   assign wr_word = {ts_cnt, bus.I_data};
`else
   assign wr_word = bus.I_data;
`endif

   // State register.
   always_ff @(posedge I_clk) begin
      if (I_rst) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; abort overrides everything else.
   always_comb begin
      state_nxt = state;
      if (bus.I_abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: if (bus.I_arm) state_nxt = ARM_STATE;
            ST_PRE:   if (bus.I_sample_en && (pre_cnt + CW'(1)) == PRE_CNT) state_nxt = ST_ARMED;
            ST_ARMED: if (bus.I_sample_en && hit)
                         state_nxt = (POST_CNT == CW'(1)) ? ST_DONE : ST_POST;
            ST_POST:  if (bus.I_sample_en && (post_cnt + CW'(1)) == POST_CNT) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // Pointers, counters, status flags and readout handshake.
   // The window is exactly DEPTH contiguous writes, so the oldest sample
   // (trigger - PRE_TRIG) is the slot just after the final write; that slot
   // is wr_ptr once DONE is entered, and it stays frozen there while reading.
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         pre_cnt    <= '0;
         post_cnt   <= '0;
         prev_match <= 1'b0;
         triggered  <= 1'b0;
         done       <= 1'b0;
         rd_valid   <= 1'b0;
         rd_last    <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         rd_last  <= rd_en && ((rd_ptr + PW'(1)) == wr_ptr);
         if (bus.I_abort) begin
            triggered <= 1'b0;
            done      <= 1'b0;
         end else if (arm_ok) begin
            wr_ptr     <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            prev_match <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
         end else begin
            if (bus.I_sample_en) prev_match <= match;
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (state == ST_PRE && bus.I_sample_en) pre_cnt <= pre_cnt + CW'(1);
            if (state == ST_ARMED && bus.I_sample_en && hit) begin
               triggered <= 1'b1;
               post_cnt  <= CW'(1);
            end
            if (state == ST_POST && bus.I_sample_en) post_cnt <= post_cnt + CW'(1);
            if (state_nxt == ST_DONE && state != ST_DONE) begin
               done   <= 1'b1;
               rd_ptr <= wr_ptr + PW'(1);
            end else if (rd_en) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
         end
      end
   end

   la_cap_ram #(.WIDTH(RD_W), .DEPTH(DEPTH)) u_ram (
      .clk   (I_clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (wr_word),
      .re    (rd_en),
      .raddr (rd_ptr),
      .rdata (rd_word)
   );

   assign bus.O_rd_data   = rd_valid ? rd_word : '0;
   assign bus.O_rd_valid  = rd_valid;
   assign bus.O_rd_last   = rd_last;
   assign bus.O_state     = state;
   assign bus.O_triggered = triggered;
   assign bus.O_done      = done;
endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core: two instances (PRE_TRIG=4 and PRE_TRIG=0,
// DEPTH=16) share one stimulus stream. Each has a queue-based model of the
// capture window checked every cycle, plus literal expectations per scenario.
// Honours LA_CAP_TSTAMP_EN when defined.
module tb_la_capture_core;
   localparam int DW    = 22;
   localparam int DEPTH = 16;
   localparam int TS_W  = 16;
`ifdef LA_CAP_TSTAMP_EN
   localparam int RDW = DW + TS_W;
`else
   localparam int RDW = DW;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          sample_en, arm, abort, rd_req;
   logic [DW-1:0] data, tmask, tval;
   logic [1:0]    mode;
   logic          started = 1'b0;
   int            errors = 0;
   int            checks = 0;
   logic [RDW-1:0] log0[$];
   logic [RDW-1:0] log1[$];

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int PRE = (g == 0) ? 4 : 0;

      la_cap_if #(.DATA_W(DW), .RD_W(RDW)) bus ();
      assign bus.I_sample_en  = sample_en;
      assign bus.I_data       = data;
      assign bus.I_arm        = arm;
      assign bus.I_abort      = abort;
      assign bus.I_trig_mode  = mode;
      assign bus.I_trig_mask  = tmask;
      assign bus.I_trig_value = tval;
      assign bus.I_rd_req     = rd_req;

      la_capture_core #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE), .TS_W(TS_W)) dut (
         .I_clk (clk),
         .I_rst (rst),
         .bus   (bus)
      );

      // Model: phase code, every word written since arm, and the frozen window.
      int             m_ph = 0;
      logic           m_trig = 1'b0, m_done = 1'b0, m_prev = 1'b0;
      logic           e_valid = 1'b0, e_last = 1'b0;
      logic [RDW-1:0] e_data = '0;
      logic [RDW-1:0] cap[$];
      logic [RDW-1:0] win[DEPTH];
      int             trig_idx = 0, rdk = 0;
      logic [TS_W-1:0] m_ts = '0;

      always @(posedge clk) begin
         logic mt, hit, arm_acc;
         logic [RDW-1:0] w;
         int ph0;
         e_valid = 1'b0;
         e_last  = 1'b0;
         if (rst) begin
            m_ph = 0; m_trig = 1'b0; m_done = 1'b0; m_prev = 1'b0; m_ts = '0;
            cap.delete();
         end else begin
            ph0 = m_ph;
            mt  = ((data ^ tval) & tmask) == '0;
            case (mode)
               2'd0:    hit = mt;
               2'd1:    hit = mt && !m_prev;
               2'd2:    hit = !mt && m_prev;
               default: hit = 1'b1;
            endcase
`ifdef LA_CAP_TSTAMP_EN
            w = {m_ts, data};
`else
            w = data;
`endif
            arm_acc = !abort && arm && (ph0 == 0 || ph0 == 4);
            if (abort) begin
               m_ph = 0; m_trig = 1'b0; m_done = 1'b0;
            end else begin
               if (ph0 == 4 && rd_req) begin
                  e_valid = 1'b1;
                  e_data  = win[rdk];
                  e_last  = (rdk == DEPTH - 1);
                  rdk     = (rdk + 1) % DEPTH;
               end
               if (sample_en) begin
                  if (ph0 >= 1 && ph0 <= 3) cap.push_back(w);
                  if (ph0 == 1 && cap.size() == PRE) m_ph = 2;
                  else if (ph0 == 2 && hit) begin
                     trig_idx = cap.size() - 1;
                     m_trig   = 1'b1;
                     m_ph     = 3;
                  end
                  if (m_ph == 3 && cap.size() - trig_idx == DEPTH - PRE) begin
                     m_ph   = 4;
                     m_done = 1'b1;
                     for (int i = 0; i < DEPTH; i++) win[i] = cap[trig_idx - PRE + i];
                     rdk = 0;
                  end
                  m_prev = mt;
               end
               if (arm_acc) begin
                  m_ph = (PRE == 0) ? 2 : 1;
                  cap.delete();
                  m_prev = 1'b0; m_trig = 1'b0; m_done = 1'b0;
               end
            end
            if (arm_acc) m_ts = '0;
            else if (sample_en) m_ts = m_ts + 1'b1;
         end
      end

      // Per-cycle compare, away from the active edge.
      always @(negedge clk) begin
         if (started) begin
            check($sformatf("i%0d_state", g), 64'(bus.O_state), 64'(m_ph));
            check($sformatf("i%0d_triggered", g), 64'(bus.O_triggered), 64'(m_trig));
            check($sformatf("i%0d_done", g), 64'(bus.O_done), 64'(m_done));
            check($sformatf("i%0d_rd_valid", g), 64'(bus.O_rd_valid), 64'(e_valid));
            if (e_valid) begin
               check($sformatf("i%0d_rd_data", g), 64'(bus.O_rd_data), 64'(e_data));
               check($sformatf("i%0d_rd_last", g), 64'(bus.O_rd_last), 64'(e_last));
            end
            if (bus.O_rd_valid) begin
               if (g == 0) log0.push_back(bus.O_rd_data);
               else        log1.push_back(bus.O_rd_data);
            end
         end
      end
   end

   task automatic idle(input int n);
      sample_en = 1'b0; arm = 1'b0; abort = 1'b0; rd_req = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_arm(input logic [1:0] m, input logic [DW-1:0] mk, input logic [DW-1:0] v);
      mode = m; tmask = mk; tval = v; arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic smp(input logic [DW-1:0] d);
      data = d; sample_en = 1'b1;
      @(negedge clk);
      sample_en = 1'b0;
   endtask

   task automatic read_n(input int n, input bit gaps);
      log0.delete(); log1.delete();
      for (int i = 0; i < n; i++) begin
         rd_req = 1'b1;
         @(negedge clk);
         if (gaps) begin
            rd_req = 1'b0;
            @(negedge clk);
         end
      end
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [63:0] dat(input logic [RDW-1:0] w);
      return 64'(w[DW-1:0]);
   endfunction

   function automatic logic [DW-1:0] tog(input int k);
      return DW'((k << 1) | ((k / 3) % 2));
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sample_en = 1'b0; arm = 1'b0; abort = 1'b0; rd_req = 1'b0;
      data = '0; tmask = '0; tval = '0; mode = 2'd0;
      @(posedge clk);
      started = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_state0", 64'(g_dut[0].bus.O_state), 64'd0);
      check("rst_done1", 64'(g_dut[1].bus.O_done), 64'd0);
      check("rst_rd_data0", 64'(g_dut[0].bus.O_rd_data), 64'd0);

      // Level trigger on ramp data, value 5.
      do_arm(2'd0, 22'h3FFFFF, 22'h000005);
      for (int k = 1; k <= 24; k++) smp(DW'(k));
      check("lvl_done0", 64'(g_dut[0].bus.O_done), 64'd1);
      check("lvl_trig1", 64'(g_dut[1].bus.O_triggered), 64'd1);
      read_n(17, 1'b0);
      check("lvl_cnt0", 64'(log0.size()), 64'd17);
      check("lvl_w0_i0", dat(log0[0]), 64'd1);
      check("lvl_w4_i0", dat(log0[4]), 64'd5);
      check("lvl_w15_i0", dat(log0[15]), 64'd16);
      check("lvl_wrap_i0", dat(log0[16]), 64'd1);
      check("lvl_w0_i1", dat(log1[0]), 64'd5);
      check("lvl_w15_i1", dat(log1[15]), 64'd20);

      // Rising edge on bit0, toggling every 3 samples; arm from DONE.
      do_arm(2'd1, 22'h000001, 22'h000001);
      for (int k = 0; k < 24; k++) smp(tog(k));
      read_n(16, 1'b1);
      check("rise_w0_i0", dat(log0[0]), 64'd11);
      check("rise_w4_i0", dat(log0[4]), 64'd19);
      check("rise_w0_i1", dat(log1[0]), 64'd7);

      // Falling edge on the same pattern.
      do_arm(2'd2, 22'h000001, 22'h000001);
      for (int k = 0; k < 24; k++) smp(tog(k));
      read_n(16, 1'b0);
      check("fall_w0_i0", dat(log0[0]), 64'd4);
      check("fall_w4_i0", dat(log0[4]), 64'd12);
      check("fall_w0_i1", dat(log1[0]), 64'd12);

      // Immediate trigger: PRE_TRIG=0 instance completes after exactly DEPTH strobes.
      do_arm(2'd3, 22'h0, 22'h0);
      for (int k = 0; k < 15; k++) smp(DW'(100 + k));
      check("imm_notdone_i1", 64'(g_dut[1].bus.O_done), 64'd0);
      smp(DW'(115));
      check("imm_done_i1", 64'(g_dut[1].bus.O_done), 64'd1);
      for (int k = 16; k < 24; k++) smp(DW'(100 + k));
      read_n(16, 1'b0);
      check("imm_w0_i1", dat(log1[0]), 64'd100);
      check("imm_w15_i1", dat(log1[15]), 64'd115);
      check("imm_w4_i0", dat(log0[4]), 64'd104);
      check("imm_w15_i0", dat(log0[15]), 64'd115);

      // Abort during POST, with arm and sample in the same cycle.
      do_arm(2'd0, 22'h3FFFFF, 22'h000005);
      for (int k = 1; k <= 8; k++) smp(DW'(k));
      check("abort_pre_state0", 64'(g_dut[0].bus.O_state), 64'd3);
      abort = 1'b1; arm = 1'b1; sample_en = 1'b1; data = DW'(9);
      @(negedge clk);
      idle(0);
      check("abort_state0", 64'(g_dut[0].bus.O_state), 64'd0);
      check("abort_state1", 64'(g_dut[1].bus.O_state), 64'd0);
      check("abort_trig0", 64'(g_dut[0].bus.O_triggered), 64'd0);
      check("abort_done1", 64'(g_dut[1].bus.O_done), 64'd0);
      read_n(2, 1'b0);
      check("abort_novalid", 64'(log0.size() + log1.size()), 64'd0);
      do_arm(2'd0, 22'h3FFFFF, 22'h000005);
      for (int k = 1; k <= 24; k++) smp(DW'(k));
      read_n(16, 1'b0);
      check("rearm_w4_i0", dat(log0[4]), 64'd5);

      // Long ARMED period (wraps the buffer) with ignored re-arms.
      do_arm(2'd0, 22'h3FFFFF, 22'd58);
      for (int k = 1; k <= 80; k++) begin
         if (k == 3 || k == 30) arm = 1'b1;
         smp(DW'(k));
         arm = 1'b0;
      end
      read_n(16, 1'b0);
      check("wrap_w0_i0", dat(log0[0]), 64'd54);
      check("wrap_w4_i0", dat(log0[4]), 64'd58);
      check("wrap_w15_i0", dat(log0[15]), 64'd69);
      check("wrap_w0_i1", dat(log1[0]), 64'd58);

      // Sparse strobes, one in seven cycles.
      do_arm(2'd0, 22'h3FFFFF, 22'h000005);
      for (int k = 1; k <= 24; k++) begin
         smp(DW'(k));
         idle(6);
      end
      read_n(16, 1'b0);
      check("sparse_w4_i0", dat(log0[4]), 64'd5);
`ifdef LA_CAP_TSTAMP_EN
      check("sparse_ts_step", 64'(log0[1][RDW-1:DW] - log0[0][RDW-1:DW]), 64'd1);
      check("sparse_ts_w0_i0", 64'(log0[0][RDW-1:DW]), 64'd0);
`else
      check("rd_width", 64'($bits(g_dut[0].bus.O_rd_data)), 64'(DW));
`endif

      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
